checker_ctlif_mc: RTL

CHECKER_CTLIF_MC -- requirements
Module: checker_ctlif_mc

---
 rtl/checker_ctlif_mc_if.sv | 10 +
 rtl/checker_ctlif_mc.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/checker_ctlif_mc_if.sv
// CSR bus bundle for checker_ctlif_mc: address, write strobe, write data and registered read data.
interface checker_ctlif_mc_if;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;

  modport master (output csr_a, output csr_we, output csr_di, input csr_do);
  modport slave  (input csr_a, input csr_we, input csr_di, output csr_do);
endinterface

// File: rtl/checker_ctlif_mc.sv
// Multi-channel checker control block: CSR register file, per-channel run FSM and interrupt aggregation.
// Optional macro CHECKER_CTLIF_MC_DATA_EN adds per-channel 64-bit result capture (DATA_LOW/DATA_HIGH).
module checker_ctlif_mc #(
  parameter int unsigned CHANNELS = 4,
  parameter logic [3:0]  CSR_ADDR = 4'h0
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  checker_ctlif_mc_if.slave      csr,
  output logic                   irq,
  output logic [2*CHANNELS-1:0]  mode_mode,
  output logic [CHANNELS-1:0]    mode_start,
  output logic [64*CHANNELS-1:0] mode_addr,
  input  logic [CHANNELS-1:0]    mode_end,
  input  logic [CHANNELS-1:0]    mode_irq,
  input  logic [CHANNELS-1:0]    mode_error,
  input  logic [64*CHANNELS-1:0] mode_data,
  output logic [CHANNELS-1:0]    mode_ack
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [4:0] GLOBAL_CH = 5'd31;

  state_t              state_r   [CHANNELS];
  logic [1:0]          mode_r    [CHANNELS];
  logic [2:0]          stat_r    [CHANNELS];
  logic [31:0]         addr_lo_r [CHANNELS];
  logic [31:0]         addr_hi_r [CHANNELS];
`ifdef CHECKER_CTLIF_MC_DATA_EN
  logic [63:0]         data_r    [CHANNELS];
`endif
  logic [CHANNELS-1:0] irq_en_r, start_r, ack_r;
  logic                irq_r;
  logic [31:0]         csr_do_r;

  logic                blk_hit_s;
  logic [4:0]          ch_idx_s;
  logic [2:0]          reg_idx_s;
  logic [CHANNELS-1:0] sel_s, wr_ctrl_s, wr_stat_s, wr_alo_s, wr_ahi_s, ctrl_upd_s;
  logic [CHANNELS-1:0] set_end_s, set_err_s, set_irq_s, irq_en_nxt_s, pend_s, pend_nxt_s;
  logic [2:0]          stat_nxt_s [CHANNELS];
  logic [31:0]         rd_ch_s    [CHANNELS];
  logic [31:0]         rd_data_s;
  logic                unused_bits_s;

  assign blk_hit_s = (csr.csr_a[13:10] == CSR_ADDR);
  assign ch_idx_s  = csr.csr_a[7:3];
  assign reg_idx_s = csr.csr_a[2:0];

`ifdef CHECKER_CTLIF_MC_DATA_EN
  assign unused_bits_s = ^csr.csr_a[9:8];
`else
  assign unused_bits_s = ^{csr.csr_a[9:8], mode_data};
`endif

  // Address decode, event qualification and next STAT/irq_en values per channel.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sel_s[i]      = blk_hit_s && (ch_idx_s == 5'(i));
      wr_ctrl_s[i]  = sel_s[i] && csr.csr_we && (reg_idx_s == 3'd0);
      wr_stat_s[i]  = sel_s[i] && csr.csr_we && (reg_idx_s == 3'd1);
      wr_alo_s[i]   = sel_s[i] && csr.csr_we && (reg_idx_s == 3'd2) && (state_r[i] != ST_RUN);
      wr_ahi_s[i]   = sel_s[i] && csr.csr_we && (reg_idx_s == 3'd3) && (state_r[i] != ST_RUN);
      // A start=1 write outside IDLE must not touch mode or irq_en either.
      ctrl_upd_s[i] = wr_ctrl_s[i] && (!csr.csr_di[3] || (state_r[i] == ST_IDLE));
      set_err_s[i]  = (state_r[i] == ST_RUN) && mode_error[i];
      set_end_s[i]  = (state_r[i] == ST_RUN) && mode_end[i] && !mode_error[i];
      set_irq_s[i]  = (state_r[i] == ST_RUN) && mode_irq[i];
      stat_nxt_s[i] = (stat_r[i] & ~(wr_stat_s[i] ? csr.csr_di[2:0] : 3'd0))
                    | {set_err_s[i], set_irq_s[i], set_end_s[i]};
      irq_en_nxt_s[i] = ctrl_upd_s[i] ? csr.csr_di[0] : irq_en_r[i];
      pend_s[i]       = irq_en_r[i] && (|stat_r[i]);
      pend_nxt_s[i]   = irq_en_nxt_s[i] && (|stat_nxt_s[i]);
    end
  end

  // Read-data mux over the current (pre-write) register contents.
  always_comb begin
    rd_data_s = (blk_hit_s && (ch_idx_s == GLOBAL_CH) && (reg_idx_s == 3'd0)) ? 32'(pend_s) : 32'd0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (reg_idx_s)
        3'd0:    rd_ch_s[i] = {28'd0, (state_r[i] == ST_RUN), mode_r[i], irq_en_r[i]};
        3'd1:    rd_ch_s[i] = {29'd0, stat_r[i]};
        3'd2:    rd_ch_s[i] = addr_lo_r[i];
        3'd3:    rd_ch_s[i] = addr_hi_r[i];
`ifdef CHECKER_CTLIF_MC_DATA_EN
        3'd4:    rd_ch_s[i] = data_r[i][31:0];
        3'd5:    rd_ch_s[i] = data_r[i][63:32];
`endif
        default: rd_ch_s[i] = 32'd0;
      endcase
      rd_data_s = rd_data_s | ({32{sel_s[i]}} & rd_ch_s[i]);
    end
  end

  // Per-channel FSMs, register file, acknowledge pulses, irq and CSR read data.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_r[i]   <= ST_IDLE;
        mode_r[i]    <= 2'd0;
        stat_r[i]    <= 3'd0;
        addr_lo_r[i] <= 32'd0;
        addr_hi_r[i] <= 32'd0;
`ifdef CHECKER_CTLIF_MC_DATA_EN
        data_r[i]    <= 64'd0;
`endif
      end
      irq_en_r <= '0;
      start_r  <= '0;
      ack_r    <= '0;
      irq_r    <= 1'b0;
      csr_do_r <= 32'd0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        stat_r[i]   <= stat_nxt_s[i];
        irq_en_r[i] <= irq_en_nxt_s[i];
        ack_r[i]    <= set_end_s[i];
        if (ctrl_upd_s[i]) mode_r[i] <= csr.csr_di[2:1];
        if (wr_alo_s[i]) addr_lo_r[i] <= csr.csr_di;
        if (wr_ahi_s[i]) addr_hi_r[i] <= csr.csr_di;
`ifdef CHECKER_CTLIF_MC_DATA_EN
        if (set_end_s[i]) data_r[i] <= mode_data[64*i +: 64];
`endif
        case (state_r[i])
          ST_IDLE: begin
            if (wr_ctrl_s[i] && csr.csr_di[3]) begin
              state_r[i] <= ST_RUN;
              start_r[i] <= 1'b1;
            end
          end
          ST_RUN: begin
            if (set_err_s[i]) begin
              state_r[i] <= ST_FAULT;
              start_r[i] <= 1'b0;
            end else if (set_end_s[i]) begin
              state_r[i] <= ST_DONE;
              start_r[i] <= 1'b0;
            end else if (wr_ctrl_s[i] && !csr.csr_di[3]) begin
              state_r[i] <= ST_IDLE;
              start_r[i] <= 1'b0;
            end
          end
          ST_DONE, ST_FAULT: begin
            if (stat_nxt_s[i][2] == 1'b0 && stat_nxt_s[i][0] == 1'b0) state_r[i] <= ST_IDLE;
          end
          default: begin
            state_r[i] <= ST_IDLE;
            start_r[i] <= 1'b0;
          end
        endcase
      end
      irq_r    <= |pend_nxt_s;
      csr_do_r <= rd_data_s;
    end
  end

  // Output packing of per-channel registers.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      mode_mode[2*i +: 2]   = mode_r[i];
      mode_addr[64*i +: 64] = {addr_hi_r[i], addr_lo_r[i]};
    end
  end

  assign mode_start = start_r;
  assign mode_ack   = ack_r;
  assign irq        = irq_r;
  assign csr.csr_do = csr_do_r;

endmodule
